// File: rtl/ascon_req_arbiter_if.sv
// Request/response and core-side signal bundle for the two-port Ascon job arbiter.
// slave = arbiter side, master = requesters plus core side.
interface ascon_req_arbiter_if #(
  parameter int k = 128,
  parameter int l = 40,
  parameter int y = 40
);
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [k-1:0] req0_key, req1_key;
  logic [127:0] req0_nonce, req1_nonce;
  logic [l-1:0] req0_ad, req1_ad;
  logic [y-1:0] req0_pt, req1_pt;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready, rsp1_ready;
  logic [y-1:0] rsp_ct;
  logic [127:0] rsp_tag;
  logic         rsp_auth, rsp_err;
  logic [k-1:0] core_key;
  logic [127:0] core_nonce;
  logic [l-1:0] core_ad;
  logic [y-1:0] core_pt;
  logic         core_start;
  logic         core_enc_done, core_dec_done, core_auth;
  logic [y-1:0] core_ct;
  logic [127:0] core_tag;
  logic         busy;

  modport slave (
    input  req0_valid, req1_valid, req0_key, req1_key, req0_nonce, req1_nonce,
           req0_ad, req1_ad, req0_pt, req1_pt, rsp0_ready, rsp1_ready,
           core_enc_done, core_dec_done, core_auth, core_ct, core_tag,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_ct, rsp_tag,
           rsp_auth, rsp_err, core_key, core_nonce, core_ad, core_pt, core_start, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_key, req1_key, req0_nonce, req1_nonce,
           req0_ad, req1_ad, req0_pt, req1_pt, rsp0_ready, rsp1_ready,
           core_enc_done, core_dec_done, core_auth, core_ct, core_tag,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_ct, rsp_tag,
           rsp_auth, rsp_err, core_key, core_nonce, core_ad, core_pt, core_start, busy
  );
endinterface

// File: rtl/ascon_req_arbiter.sv
// Round-robin sequencer sharing one Ascon AEAD core between two requesters:
// accept a job, pulse core_start, wait for decrypt done or timeout, return result to the granted port.
module ascon_req_arbiter #(
  parameter int k       = 128,
  parameter int l       = 40,
  parameter int y       = 40,
  parameter int TIMEOUT = 4095
) (
  input logic            clk,
  input logic            rst,
  ascon_req_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_t       state;
  logic         last, gnt;
  logic         grant0, grant1;
  logic [15:0]  cnt;
  logic [k-1:0] key_q;
  logic [127:0] nonce_q;
  logic [l-1:0] ad_q;
  logic [y-1:0] pt_q;
  logic [y-1:0] ct_q;
  logic [127:0] tag_q;
  logic         auth_q, err_q, start_q, busy_q, rsp0_valid_q, rsp1_valid_q;

  // With both ports valid, the one not granted last wins.
  always_comb begin
    grant0 = bus.req0_valid && (!bus.req1_valid || last);
    grant1 = bus.req1_valid && (!bus.req0_valid || !last);
  end

  assign bus.req0_ready = (state == IDLE) && grant0;
  assign bus.req1_ready = (state == IDLE) && grant1;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp_ct     = ct_q;
  assign bus.rsp_tag    = tag_q;
  assign bus.rsp_auth   = auth_q;
  assign bus.rsp_err    = err_q;
  assign bus.core_key   = key_q;
  assign bus.core_nonce = nonce_q;
  assign bus.core_ad    = ad_q;
  assign bus.core_pt    = pt_q;
  assign bus.core_start = start_q;
  assign bus.busy       = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last         <= 1'b1;
      gnt          <= 1'b0;
      cnt          <= '0;
      key_q        <= '0;
      nonce_q      <= '0;
      ad_q         <= '0;
      pt_q         <= '0;
      ct_q         <= '0;
      tag_q        <= '0;
      auth_q       <= 1'b0;
      err_q        <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            gnt     <= grant1;
            last    <= grant1;
            key_q   <= grant1 ? bus.req1_key   : bus.req0_key;
            nonce_q <= grant1 ? bus.req1_nonce : bus.req0_nonce;
            ad_q    <= grant1 ? bus.req1_ad    : bus.req0_ad;
            pt_q    <= grant1 ? bus.req1_pt    : bus.req0_pt;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 16'd1;
          // cnt==0 marks the first WAIT cycle, where done may still be left over from the last job.
          if (cnt != 16'd0 && bus.core_dec_done) begin
            ct_q         <= bus.core_ct;
            tag_q        <= bus.core_tag;
            auth_q       <= bus.core_auth;
            err_q        <= 1'b0;
            rsp0_valid_q <= !gnt;
            rsp1_valid_q <= gnt;
            state        <= RESP;
          end else if (cnt + 16'd1 == TIMEOUT_CNT) begin
            ct_q         <= '0;
            tag_q        <= '0;
            auth_q       <= 1'b0;
            err_q        <= 1'b1;
            rsp0_valid_q <= !gnt;
            rsp1_valid_q <= gnt;
            state        <= RESP;
          end
        end
        RESP: begin
          if (gnt ? bus.rsp1_ready : bus.rsp0_ready) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ascon_req_arbiter.sv
// Bench for ascon_req_arbiter: behavioural core model plus job-level reference for grant order, timing and data.
`timescale 1ns/1ps
module tb_ascon_req_arbiter;
  localparam int K = 128, L = 40, Y = 40, TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ascon_req_arbiter_if #(.k(K), .l(L), .y(Y)) bus ();
  ascon_req_arbiter #(.k(K), .l(L), .y(Y), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int n_start = 0, start_cyc = -1;
  int prev_grant = 1;
  int core_lat = 2;
  int lat_cnt = 0;
  bit hold_done = 0, never_done = 0;
  logic [K-1:0] drv_key[2];
  logic [127:0] drv_nonce[2];
  logic [L-1:0] drv_ad[2];
  logic [Y-1:0] drv_pt[2];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.core_start === 1'b1) begin n_start++; start_cyc = cyc; end

  function automatic logic [Y-1:0] f_ct(input logic [K-1:0] key, input logic [L-1:0] ad, input logic [Y-1:0] pt);
    return pt ^ ad ^ key[Y-1:0] ^ 40'h5A5A5A5A5A;
  endfunction
  function automatic logic [127:0] f_tag(input logic [K-1:0] key, input logic [127:0] nonce, input logic [Y-1:0] pt);
    return {key[63:0], key[127:64]} ^ nonce ^ {88'd0, pt};
  endfunction
  function automatic logic f_auth(input logic [K-1:0] key, input logic [127:0] nonce);
    return ~(key[0] ^ nonce[0]);
  endfunction
  // Wait-cycle index at which the job resolves: done is honoured from the 2nd cycle, timeout caps it.
  function automatic int exp_n(input int lat, input bit never);
    if (never || lat + 1 > TO) return TO;
    return (lat + 1 < 2) ? 2 : lat + 1;
  endfunction

  // Core model: done levels persist until the next start; hold_done leaves a stale done asserted.
  always @(posedge clk) begin
    if (rst) begin
      bus.core_dec_done <= 1'b0; bus.core_enc_done <= 1'b0; bus.core_auth <= 1'b0;
      bus.core_ct <= '0; bus.core_tag <= '0; lat_cnt <= 0;
    end else if (bus.core_start) begin
      if (hold_done) begin
        bus.core_ct   <= f_ct(bus.core_key, bus.core_ad, bus.core_pt);
        bus.core_tag  <= f_tag(bus.core_key, bus.core_nonce, bus.core_pt);
        bus.core_auth <= f_auth(bus.core_key, bus.core_nonce);
      end else begin
        bus.core_dec_done <= 1'b0; bus.core_enc_done <= 1'b0;
      end
      lat_cnt <= never_done ? 0 : core_lat;
    end else if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) begin
        bus.core_dec_done <= 1'b1; bus.core_enc_done <= 1'b1;
        bus.core_ct   <= f_ct(bus.core_key, bus.core_ad, bus.core_pt);
        bus.core_tag  <= f_tag(bus.core_key, bus.core_nonce, bus.core_pt);
        bus.core_auth <= f_auth(bus.core_key, bus.core_nonce);
      end
    end
  end

  task automatic set_port(input int p, input logic [K-1:0] key, input logic [127:0] nonce,
                          input logic [L-1:0] ad, input logic [Y-1:0] pt);
    drv_key[p] = key; drv_nonce[p] = nonce; drv_ad[p] = ad; drv_pt[p] = pt;
    if (p == 0) begin bus.req0_key = key; bus.req0_nonce = nonce; bus.req0_ad = ad; bus.req0_pt = pt; end
    else begin bus.req1_key = key; bus.req1_nonce = nonce; bus.req1_ad = ad; bus.req1_pt = pt; end
  endtask

  task automatic rand_port(input int p);
    logic [63:0] a, b;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    set_port(p, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
             a[L-1:0], b[Y-1:0]);
  endtask

  task automatic wait_accept(output int p, output int t, output bit to);
    p = -1; t = 0; to = 1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.req0_valid && bus.req0_ready) begin p = 0; t = cyc; to = 0; break; end
      if (bus.req1_valid && bus.req1_ready) begin p = 1; t = cyc; to = 0; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_rsp(input int p, output int t, output bit to, output bit other, output bit rdy);
    t = 0; to = 1; other = 0; rdy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((p == 0) ? bus.rsp1_valid : bus.rsp0_valid) other = 1;
      if ((p == 0) ? bus.rsp0_valid : bus.rsp1_valid) begin t = cyc; to = 0; break; end
      if (bus.req0_ready || bus.req1_ready) rdy = 1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; bus.req0_valid = 0; bus.req1_valid = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0; prev_grant = 1;
  endtask

  task automatic test_reset();
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    rand_port(0); rand_port(1);
    apply_reset();
    #1;
    n_checks++; if (bus.req0_ready !== 0 || bus.req1_ready !== 0) begin n_fail++; $display("FAIL reset_ready: got %b%b required 00", bus.req0_ready, bus.req1_ready); end
    n_checks++; if (bus.rsp0_valid !== 0 || bus.rsp1_valid !== 0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b%b required 00", bus.rsp0_valid, bus.rsp1_valid); end
    n_checks++; if (bus.core_start !== 0 || bus.busy !== 0) begin n_fail++; $display("FAIL reset_start_busy: got %b%b required 00", bus.core_start, bus.busy); end
    n_checks++; if (bus.rsp_ct !== 0 || bus.rsp_tag !== 0 || bus.rsp_auth !== 0 || bus.rsp_err !== 0) begin n_fail++; $display("FAIL reset_rsp_data: ct %h tag %h auth %b err %b required zero", bus.rsp_ct, bus.rsp_tag, bus.rsp_auth, bus.rsp_err); end
    n_checks++; if (bus.core_key !== 0 || bus.core_nonce !== 0 || bus.core_ad !== 0 || bus.core_pt !== 0) begin n_fail++; $display("FAIL reset_core_ops: key %h required 0", bus.core_key); end
  endtask

  task automatic test_alternate();
    int p, t, tr; bit to, to2, oth, rdy;
    logic [Y-1:0] ect; logic [127:0] etag;
    bus.req0_valid = 1; bus.req1_valid = 1;
    for (int j = 0; j < 4; j++) begin
      core_lat = $urandom_range(1, 5);
      wait_accept(p, t, to);
      n_checks++; if (to !== 0 || p !== (j % 2)) begin n_fail++; $display("FAIL alt_grant[%0d]: got %0d required %0d", j, p, j % 2); end
      if (p < 0) p = 0;
      ect = f_ct(drv_key[p], drv_ad[p], drv_pt[p]); etag = f_tag(drv_key[p], drv_nonce[p], drv_pt[p]);
      prev_grant = p;
      @(negedge clk); rand_port(p);
      wait_rsp(p, tr, to2, oth, rdy);
      n_checks++; if (to2 !== 0 || tr !== t + 2 + exp_n(core_lat, 0)) begin n_fail++; $display("FAIL alt_rsp_time[%0d]: got %0d required %0d", j, tr, t + 2 + exp_n(core_lat, 0)); end
      n_checks++; if (rdy !== 0) begin n_fail++; $display("FAIL alt_ready_while_busy[%0d]: got 1 required 0", j); end
      n_checks++; if (bus.rsp_ct !== ect || bus.rsp_tag !== etag) begin n_fail++; $display("FAIL alt_data[%0d]: ct %h required %h", j, bus.rsp_ct, ect); end
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
  endtask

  task automatic test_single_job();
    int p, t, tr, s0; bit to, to2, oth, rdy;
    set_port(0, 128'hAABBCCDDEEFF00112233445566778899, 128'h0123456789ABCDEF0123456789ABCDEF, 40'h0123456789, 40'hABCDEF0123);
    core_lat = 3; s0 = n_start;
    bus.req0_valid = 1;
    wait_accept(p, t, to);
    @(negedge clk); bus.req0_valid = 0;
    wait_rsp(0, tr, to2, oth, rdy);
    n_checks++; if (to !== 0 || p !== 0) begin n_fail++; $display("FAIL single_grant: got %0d required 0", p); end
    n_checks++; if (start_cyc !== t + 1 || n_start !== s0 + 1) begin n_fail++; $display("FAIL single_start: cycle %0d count %0d required %0d 1", start_cyc, n_start - s0, t + 1); end
    n_checks++; if (bus.core_key !== drv_key[0] || bus.core_nonce !== drv_nonce[0] || bus.core_ad !== drv_ad[0] || bus.core_pt !== drv_pt[0]) begin n_fail++; $display("FAIL single_core_ops: key %h required %h", bus.core_key, drv_key[0]); end
    n_checks++; if (to2 !== 0 || tr !== t + 6) begin n_fail++; $display("FAIL single_rsp_time: got %0d required %0d", tr, t + 6); end
    n_checks++; if (oth !== 0) begin n_fail++; $display("FAIL single_rsp1_valid: got 1 required 0"); end
    n_checks++; if (bus.rsp_ct !== f_ct(drv_key[0], drv_ad[0], drv_pt[0]) || bus.rsp_tag !== f_tag(drv_key[0], drv_nonce[0], drv_pt[0])) begin n_fail++; $display("FAIL single_data: ct %h tag %h", bus.rsp_ct, bus.rsp_tag); end
    n_checks++; if (bus.rsp_auth !== 1 || bus.rsp_err !== 0) begin n_fail++; $display("FAIL single_auth_err: got %b%b required 10", bus.rsp_auth, bus.rsp_err); end
    prev_grant = 0;
  endtask

  task automatic test_stale();
    int p, t, tr; bit to, to2, oth, rdy;
    rand_port(1); hold_done = 1; core_lat = 5;
    bus.req1_valid = 1;
    wait_accept(p, t, to);
    @(negedge clk); bus.req1_valid = 0;
    wait_rsp(1, tr, to2, oth, rdy);
    n_checks++; if (to2 !== 0 || tr !== t + 4) begin n_fail++; $display("FAIL stale_rsp_time: got %0d required %0d", tr, t + 4); end
    n_checks++; if (bus.rsp_ct !== f_ct(drv_key[1], drv_ad[1], drv_pt[1]) || bus.rsp_err !== 0) begin n_fail++; $display("FAIL stale_data: ct %h err %b", bus.rsp_ct, bus.rsp_err); end
    hold_done = 0; prev_grant = 1;
  endtask

  task automatic test_timeout();
    int p, t, tr; bit to, to2, oth, rdy;
    rand_port(0); never_done = 1;
    bus.req0_valid = 1;
    wait_accept(p, t, to);
    @(negedge clk); bus.req0_valid = 0;
    wait_rsp(0, tr, to2, oth, rdy);
    n_checks++; if (to2 !== 0 || tr !== t + 2 + TO) begin n_fail++; $display("FAIL timeout_time: got %0d required %0d", tr, t + 2 + TO); end
    n_checks++; if (bus.rsp_err !== 1 || bus.rsp_ct !== 0 || bus.rsp_tag !== 0 || bus.rsp_auth !== 0) begin n_fail++; $display("FAIL timeout_data: err %b ct %h tag %h auth %b required 1 0 0 0", bus.rsp_err, bus.rsp_ct, bus.rsp_tag, bus.rsp_auth); end
    never_done = 0; prev_grant = 0;
  endtask

  task automatic test_backpressure();
    int p, t, tr, rel; bit to, to2, oth, rdy, stab_bad, rdy_bad;
    logic [Y-1:0] ct0; logic [127:0] tag0; logic a0, e0;
    rand_port(0); rand_port(1); core_lat = 2;
    bus.rsp1_ready = 0; bus.req1_valid = 1;
    wait_accept(p, t, to);
    n_checks++; if (to !== 0 || p !== 1) begin n_fail++; $display("FAIL bp_grant: got %0d required 1", p); end
    @(negedge clk); bus.req1_valid = 0; bus.req0_valid = 1;
    wait_rsp(1, tr, to2, oth, rdy);
    n_checks++; if (to2 !== 0 || rdy !== 0) begin n_fail++; $display("FAIL bp_rsp: timeout %b ready_seen %b required 0 0", to2, rdy); end
    ct0 = bus.rsp_ct; tag0 = bus.rsp_tag; a0 = bus.rsp_auth; e0 = bus.rsp_err;
    n_checks++; if (ct0 !== f_ct(drv_key[1], drv_ad[1], drv_pt[1])) begin n_fail++; $display("FAIL bp_data: ct %h required %h", ct0, f_ct(drv_key[1], drv_ad[1], drv_pt[1])); end
    stab_bad = 0; rdy_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp1_valid !== 1 || bus.rsp_ct !== ct0 || bus.rsp_tag !== tag0 || bus.rsp_auth !== a0 || bus.rsp_err !== e0) stab_bad = 1;
      if (bus.req0_ready !== 0) rdy_bad = 1;
    end
    n_checks++; if (stab_bad !== 0) begin n_fail++; $display("FAIL bp_stable: got unstable required stable"); end
    n_checks++; if (rdy_bad !== 0) begin n_fail++; $display("FAIL bp_req0_ready: got 1 required 0"); end
    bus.rsp1_ready = 1; rel = cyc;
    wait_accept(p, t, to);
    n_checks++; if (to !== 0 || p !== 0 || t !== rel + 1) begin n_fail++; $display("FAIL bp_resume: port %0d cycle %0d required 0 %0d", p, t, rel + 1); end
    @(negedge clk); bus.req0_valid = 0;
    wait_rsp(0, tr, to2, oth, rdy);
    prev_grant = 0;
  endtask

  task automatic test_random();
    int p, t, tr, ep, n; bit to, to2, oth, rdy, v0, v1, never;
    for (int j = 0; j < 10; j++) begin
      int v;
      v = $urandom_range(1, 3); v0 = v[0]; v1 = v[1];
      rand_port(0); rand_port(1);
      never = ($urandom_range(0, 5) == 0);
      core_lat = $urandom_range(1, 9); never_done = never;
      ep = (v0 && v1) ? ((prev_grant == 0) ? 1 : 0) : (v0 ? 0 : 1);
      n = exp_n(core_lat, never);
      bus.req0_valid = v0; bus.req1_valid = v1;
      wait_accept(p, t, to);
      @(negedge clk); bus.req0_valid = 0; bus.req1_valid = 0;
      n_checks++; if (to !== 0 || p !== ep) begin n_fail++; $display("FAIL rand_grant[%0d]: got %0d required %0d", j, p, ep); end
      wait_rsp(ep, tr, to2, oth, rdy);
      n_checks++; if (to2 !== 0 || tr !== t + 2 + n || start_cyc !== t + 1) begin n_fail++; $display("FAIL rand_time[%0d]: rsp %0d start %0d required %0d %0d", j, tr, start_cyc, t + 2 + n, t + 1); end
      if (n == TO && (never || core_lat + 1 > TO)) begin
        n_checks++; if (bus.rsp_err !== 1 || bus.rsp_ct !== 0 || bus.rsp_tag !== 0 || bus.rsp_auth !== 0) begin n_fail++; $display("FAIL rand_timeout_data[%0d]: err %b ct %h", j, bus.rsp_err, bus.rsp_ct); end
      end else begin
        n_checks++; if (bus.rsp_err !== 0 || bus.rsp_ct !== f_ct(drv_key[ep], drv_ad[ep], drv_pt[ep]) || bus.rsp_tag !== f_tag(drv_key[ep], drv_nonce[ep], drv_pt[ep]) || bus.rsp_auth !== f_auth(drv_key[ep], drv_nonce[ep])) begin n_fail++; $display("FAIL rand_data[%0d]: err %b ct %h required %h", j, bus.rsp_err, bus.rsp_ct, f_ct(drv_key[ep], drv_ad[ep], drv_pt[ep])); end
      end
      prev_grant = ep;
    end
    never_done = 0;
  endtask

  task automatic test_async_reset();
    int p, t, tr, s0; bit to, to2, oth, rdy;
    rand_port(0); core_lat = 6; s0 = n_start;
    bus.req0_valid = 1;
    wait_accept(p, t, to);
    @(negedge clk); bus.req0_valid = 0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 0 || bus.rsp0_valid !== 0 || bus.rsp1_valid !== 0 || bus.core_start !== 0) begin n_fail++; $display("FAIL areset_ctrl: busy %b rsp %b%b start %b required 0", bus.busy, bus.rsp0_valid, bus.rsp1_valid, bus.core_start); end
    n_checks++; if (bus.core_key !== 0 || bus.rsp_ct !== 0 || bus.rsp_tag !== 0 || bus.rsp_err !== 0) begin n_fail++; $display("FAIL areset_data: key %h ct %h required 0", bus.core_key, bus.rsp_ct); end
    repeat (2) @(negedge clk);
    rst = 1'b0; prev_grant = 1;
    repeat (3) @(negedge clk);
    n_checks++; if (n_start !== s0 + 1 || bus.busy !== 0) begin n_fail++; $display("FAIL areset_no_start: starts %0d busy %b required 1 0", n_start - s0, bus.busy); end
    rand_port(0); rand_port(1); core_lat = 2;
    bus.req0_valid = 1; bus.req1_valid = 1;
    wait_accept(p, t, to);
    @(negedge clk); bus.req0_valid = 0; bus.req1_valid = 0;
    n_checks++; if (to !== 0 || p !== 0) begin n_fail++; $display("FAIL areset_grant: got %0d required 0", p); end
    wait_rsp(0, tr, to2, oth, rdy);
    n_checks++; if (to2 !== 0 || tr !== t + 5 || bus.rsp_ct !== f_ct(drv_key[0], drv_ad[0], drv_pt[0])) begin n_fail++; $display("FAIL areset_job: rsp %0d ct %h required %0d", tr, bus.rsp_ct, t + 5); end
    prev_grant = 0;
  endtask

  initial begin
    bus.req0_valid = 0; bus.req1_valid = 0;
    test_reset();
    test_alternate();
    test_single_job();
    test_stale();
    test_timeout();
    test_backpressure();
    test_random();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
